// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and memory-side bus bundle for dcache_ctrl
//
// Purpose: groups the MEM-stage request/response signals and the block-wide
// memory handshake so the cache and its environment share one port object.
// Port summary (cache view = slave modport):
//   p_addr_i, p_data_i, p_MemRead_i, p_MemWrite_i   CPU request (in)
//   p_data_o, p_stall_o                             CPU response (out)
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o   memory request (out)
//   mem_data_i, mem_ack_i                           memory response (in)
interface dcache_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_BITS = 256
);
    logic [ADDR_W-1:0]     p_addr_i;
    logic [31:0]           p_data_i;
    logic                  p_MemRead_i;
    logic                  p_MemWrite_i;
    logic [31:0]           p_data_o;
    logic                  p_stall_o;
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  p_addr_i, p_data_i, p_MemRead_i, p_MemWrite_i, mem_data_i, mem_ack_i,
        output p_data_o, p_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p_addr_i, p_data_i, p_MemRead_i, p_MemWrite_i, mem_data_i, mem_ack_i,
        input  p_data_o, p_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache
//
// Purpose: serves MEM-stage loads/stores from an internal line array; misses
// stall the pipeline while a dirty victim is written back and the line refilled.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   asynchronous active-low reset (clears valid/dirty, FSM, memory regs)
//   bus     dcache_ctrl_if.slave: CPU request/response and block memory handshake
module dcache_ctrl #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256,
    parameter int ADDR_W     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);
    localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WSEL_W = $clog2(BLOCK_BITS / 32);

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [BLOCK_BITS-1:0] r_data [LINES];
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic                  r_mem_enable;
    logic                  r_mem_write;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [BLOCK_BITS-1:0] r_mem_data;

    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [WSEL_W-1:0]     w_wsel;
    logic [BLOCK_BITS-1:0] w_line;
    logic [31:0]           w_word;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_store_hit;
    logic                  w_wb_start;
    logic                  w_alloc_start;
    logic                  w_fill;

    assign w_idx  = bus.p_addr_i[OFF_W +: IDX_W];
    assign w_tag  = bus.p_addr_i[ADDR_W-1 -: TAG_W];
    assign w_wsel = bus.p_addr_i[OFF_W-1 -: WSEL_W];
    assign w_line = r_data[w_idx];
    assign w_word = w_line[{w_wsel, 5'd0} +: 32];
    assign w_req  = bus.p_MemRead_i | bus.p_MemWrite_i;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Stores only commit in IDLE; a store that missed retires here once the
    // refilled line makes it hit, which is what leaves the line dirty.
    assign w_store_hit = (r_state == S_IDLE) && bus.p_MemWrite_i && w_hit;

    assign bus.p_data_o     = (w_req && w_hit) ? w_word : 32'd0;
    assign bus.p_stall_o    = (w_req && !w_hit) || (r_state != S_IDLE);
    assign bus.mem_enable_o = r_mem_enable;
    assign bus.mem_write_o  = r_mem_write;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;

    always_comb begin
        w_next        = r_state;
        w_wb_start    = 1'b0;
        w_alloc_start = 1'b0;
        w_fill        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    if (r_valid[w_idx] && r_dirty[w_idx]) begin
                        w_next     = S_WRITEBACK;
                        w_wb_start = 1'b1;
                    end else begin
                        w_next        = S_ALLOCATE;
                        w_alloc_start = 1'b1;
                    end
                end
            end
            S_WRITEBACK: begin
                // Refill request follows straight on: enable stays high, write flips.
                if (bus.mem_ack_i) begin
                    w_next        = S_ALLOCATE;
                    w_alloc_start = 1'b1;
                end
            end
            S_ALLOCATE: begin
                if (bus.mem_ack_i) begin
                    w_next = S_IDLE;
                    w_fill = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
        end else begin
            r_state <= w_next;
            if (w_wb_start) begin
                r_mem_enable <= 1'b1;
                r_mem_write  <= 1'b1;
                r_mem_addr   <= {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                r_mem_data   <= w_line;
            end else if (w_alloc_start) begin
                r_mem_enable <= 1'b1;
                r_mem_write  <= 1'b0;
                r_mem_addr   <= {w_tag, w_idx, {OFF_W{1'b0}}};
            end else if (w_fill) begin
                r_mem_enable <= 1'b0;
            end
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_store_hit) begin
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // Line data and tags carry no reset; valid bits alone decide whether they count.
    always_ff @(posedge clk_i) begin
        if (w_fill) begin
            r_data[w_idx] <= bus.mem_data_i;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store_hit) begin
            r_data[w_idx][{w_wsel, 5'd0} +: 32] <= bus.p_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl_if bus ();
    dcache_ctrl dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    logic ack_r = 1'b0;
    logic stray_ack = 1'b0;
    assign bus.mem_ack_i = ack_r | stray_ack;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [255:0] d;
    } txn_t;
    txn_t txq[$];

    logic [31:0]  golden  [logic [31:0]];
    logic [255:0] backing [logic [31:0]];
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    int           rd_lat = 0;
    int           wb_lat = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] gword(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : init_word(a);
    endfunction

    function automatic logic [255:0] golden_blk(input logic [31:0] b);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = gword(b + 32'(4 * w));
        return r;
    endfunction

    function automatic logic [255:0] get_backing(input logic [31:0] b);
        logic [255:0] r;
        if (backing.exists(b)) return backing[b];
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = init_word(b + 32'(4 * w));
        return r;
    endfunction

    // Behavioural memory: acks lat cycles after a request is first seen, logs
    // every completed transaction and requires the request to stay constant.
    initial begin
        int          mcnt;
        bit          in_txn;
        logic        cap_w;
        logic [31:0] cap_a;
        logic [255:0] cap_d;
        mcnt = 0; in_txn = 0; cap_w = 0; cap_a = 0; cap_d = 0;
        bus.mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcnt = 0; in_txn = 0; ack_r = 1'b0;
            end else begin
                if (ack_r) begin
                    ack_r = 1'b0; in_txn = 0; mcnt = 0;
                end
                if (bus.mem_enable_o) begin
                    if (!in_txn) begin
                        in_txn = 1;
                        cap_w = bus.mem_write_o;
                        cap_a = bus.mem_addr_o;
                        cap_d = bus.mem_data_o;
                    end else begin
                        chk("hold_write", bus.mem_write_o, cap_w);
                        chk("hold_addr", bus.mem_addr_o, cap_a);
                        chk("hold_data", bus.mem_data_o, cap_d);
                    end
                    mcnt++;
                    if (mcnt == (cap_w ? wb_lat : rd_lat) + 1) begin
                        ack_r = 1'b1;
                        if (cap_w) backing[cap_a] = cap_d;
                        else bus.mem_data_i = get_backing(cap_a);
                        txq.push_back('{w: cap_w, a: cap_a, d: cap_w ? cap_d : 256'd0});
                    end
                end
            end
        end
    end

    task automatic access(input logic [31:0] a, input bit wr, input logic [31:0] d,
                          input int rl, input int wl);
        int          idx;
        int          st;
        int          exp_txn;
        bit          hit;
        bit          evict;
        logic [21:0] tg;
        logic [31:0] blk;
        logic [31:0] old_blk;
        idx     = int'(a[9:5]);
        tg      = a[31:10];
        blk     = {a[31:5], 5'b0};
        hit     = m_valid[idx] && (m_tag[idx] == tg);
        evict   = !hit && m_valid[idx] && m_dirty[idx];
        old_blk = {m_tag[idx], a[9:5], 5'b0};
        exp_txn = hit ? 0 : (evict ? 2 : 1);
        rd_lat  = rl;
        wb_lat  = wl;
        txq.delete();
        @(posedge clk); #1;
        bus.p_addr_i     = a;
        bus.p_data_i     = d;
        bus.p_MemRead_i  = !wr;
        bus.p_MemWrite_i = wr;
        st = 0;
        @(negedge clk);
        while (bus.p_stall_o && st < 400) begin
            st++;
            @(negedge clk);
        end
        chk($sformatf("stall_cycles@%0h", a), st, hit ? 0 : (rl + 2 + (evict ? wl + 1 : 0)));
        chk("enable_after", bus.mem_enable_o, 1'b0);
        if (!wr) chk($sformatf("load@%0h", a), bus.p_data_o, gword(a));
        chk("txn_count", txq.size(), exp_txn);
        if (txq.size() == exp_txn && exp_txn > 0) begin
            if (evict) begin
                chk("wb_is_write", txq[0].w, 1'b1);
                chk("wb_addr", txq[0].a, old_blk);
                chk("wb_data", txq[0].d, golden_blk(old_blk));
            end
            chk("refill_is_read", txq[exp_txn-1].w, 1'b0);
            chk("refill_addr", txq[exp_txn-1].a, blk);
        end
        @(posedge clk); #1;
        bus.p_MemRead_i  = 1'b0;
        bus.p_MemWrite_i = 1'b0;
        if (wr) golden[a] = d;
        if (!hit) begin
            m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
        end
        if (wr) m_dirty[idx] = 1;
    endtask

    // Reset drops dirty lines: their stores never reached memory.
    task automatic model_reset();
        logic [31:0]  b;
        logic [255:0] bb;
        for (int i = 0; i < 32; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                b  = {m_tag[i], 5'(i), 5'b0};
                bb = get_backing(b);
                for (int w = 0; w < 8; w++) golden[b + 32'(4 * w)] = bb[w*32 +: 32];
            end
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
        bus.p_addr_i = '0; bus.p_data_i = '0; bus.p_MemRead_i = 1'b0; bus.p_MemWrite_i = 1'b0;
        golden[32'h40]  = 32'h1234_5678;
        backing[32'h40] = golden_blk(32'h40);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_enable", bus.mem_enable_o, 1'b0);
        chk("rst_write", bus.mem_write_o, 1'b0);
        chk("rst_addr", bus.mem_addr_o, 32'd0);
        chk("rst_data", bus.mem_data_o, 256'd0);
        chk("rst_pdata", bus.p_data_o, 32'd0);
        chk("rst_stall", bus.p_stall_o, 1'b0);
        rst_n = 1'b1;

        // Clean load miss, then store hit, read-back, stray ack, dirty eviction.
        access(32'h0000_0040, 0, 0, 5, 0);
        access(32'h0000_0044, 1, 32'hDEAD_BEEF, 0, 0);
        access(32'h0000_0044, 0, 0, 0, 0);
        @(posedge clk); #1; stray_ack = 1'b1;
        @(posedge clk); #1; stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_enable", bus.mem_enable_o, 1'b0);
        chk("stray_stall", bus.p_stall_o, 1'b0);
        access(32'h0000_0044, 0, 0, 0, 0);
        access(32'h0000_0444, 0, 0, 4, 3);

        // Store miss to a clean line, read it back, then force it out.
        access(32'h0000_0084, 1, 32'hCAFE_F00D, 2, 0);
        access(32'h0000_0084, 0, 0, 0, 0);
        access(32'h0000_0480, 0, 0, 1, 2);

        // Long memory latency.
        access(32'h0000_1000, 0, 0, 20, 0);

        // Reset in the middle of a refill.
        rd_lat = 10;
        txq.delete();
        @(posedge clk); #1;
        bus.p_addr_i = 32'h0000_2000; bus.p_MemRead_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_enable", bus.mem_enable_o, 1'b1);
        chk("pre_rst_stall", bus.p_stall_o, 1'b1);
        rst_n = 1'b0; bus.p_MemRead_i = 1'b0;
        #1;
        chk("mid_rst_enable", bus.mem_enable_o, 1'b0);
        chk("mid_rst_stall", bus.p_stall_o, 1'b0);
        chk("mid_rst_addr", bus.mem_addr_o, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        access(32'h0000_2000, 0, 0, 3, 0);
        access(32'h0000_1000, 0, 0, 2, 0);

        // Random traffic over a few indices and tags to force conflicts.
        for (int n = 0; n < 40; n++) begin
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
               | (32'($urandom_range(0, 7)) << 2);
            access(ra, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
